// File: rtl/result_display_pkg.sv
// -----------------------------------------------------------------------------
// result_display_pkg
// Shared types and constants for the result display sequencer.
//   disp_state_e         : sequencer state (COLLECT a matrix, DISPLAY it)
//   CLK_FREQ_HZ          : board clock frequency (iCEBreaker, 12 MHz)
//   DWELL_SECONDS        : how long each word stays on the display
//   DWELL_CYCLES_DEFAULT : dwell expressed in clock cycles
// -----------------------------------------------------------------------------
package result_display_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DISPLAY = 1'b1
    } disp_state_e;

    localparam int CLK_FREQ_HZ          = 12_000_000;
    localparam int DWELL_SECONDS        = 5;
    localparam int DWELL_CYCLES_DEFAULT = CLK_FREQ_HZ * DWELL_SECONDS;

endpackage

// File: rtl/result_display_seq_dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Free-running dwell counter used by the display sequencer. Counts 0 through
// count_p-1 while enabled, then wraps to 0.
// Ports:
//   clk_i     : system clock
//   reset_n_i : asynchronous active-low reset
//   en_i      : count enable (sequencer is displaying)
//   clear_i   : synchronous clear, takes priority over en_i
//   expire_o  : high on the last count of a dwell period while enabled
// -----------------------------------------------------------------------------
module dwell_timer #(
    parameter int count_p = 4
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic en_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int CW = $clog2(count_p + 1);
    localparam logic [CW-1:0] LAST = CW'(count_p - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (en_i) begin
            r_count <= w_at_last ? '0 : r_count + CW'(1);
        end
    end

    assign expire_o = en_i && w_at_last;

endmodule

// File: rtl/result_display_seq.sv
// -----------------------------------------------------------------------------
// result_display_seq
// Collects one result matrix (depth_p words) from the systolic array output
// path, then shows each word in order on the seven-segment path for a fixed
// dwell time before releasing the buffer for the next matrix.
// Ports:
//   clk_i     : system clock
//   reset_n_i : asynchronous active-low reset; discards any partial matrix
//   valid_i   : upstream result word present
//   data_i    : upstream result word
//   ready_o   : block accepts a word this cycle (high only while collecting)
//   skip_i    : one-cycle pulse, advances the display early
//   data_o    : word currently displayed (0 while collecting)
//   index_o   : index of the displayed word (0 while collecting)
//   active_o  : high while displaying
//   done_o    : one-cycle pulse after the last word of a matrix was shown
// -----------------------------------------------------------------------------
module result_display_seq
    import result_display_pkg::*;
#(
    parameter int width_p        = 8,
    parameter int depth_p        = 4,
    parameter int dwell_cycles_p = DWELL_CYCLES_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       valid_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       ready_o,
    input  logic                       skip_i,
    output logic [width_p-1:0]         data_o,
    output logic [$clog2(depth_p)-1:0] index_o,
    output logic                       active_o,
    output logic                       done_o
);

    localparam int IW = $clog2(depth_p);
    localparam logic [IW-1:0] LAST_IDX = IW'(depth_p - 1);

    disp_state_e        r_state;
    logic [IW-1:0]      r_wr_cnt;
    logic [IW-1:0]      r_rd_idx;
    logic               r_done;
    logic [width_p-1:0] r_buf [depth_p];

    logic w_in_display;
    logic w_accept;
    logic w_expire;
    logic w_advance;
    logic w_timer_clear;

    assign w_in_display = (r_state == DISPLAY);
    // ready is a pure state decode, so accept never depends combinationally
    // on anything but valid_i and registered state.
    assign w_accept     = !w_in_display && valid_i;
    // Expiry and skip in the same cycle collapse into one advance.
    assign w_advance    = w_in_display && (w_expire || skip_i);
    // Keep the timer parked at 0 while collecting so the first word gets a
    // full dwell, and restart it on every advance (needed for early skips).
    assign w_timer_clear = !w_in_display || w_advance;

    dwell_timer #(
        .count_p (dwell_cycles_p)
    ) u_dwell_timer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (w_in_display),
        .clear_i   (w_timer_clear),
        .expire_o  (w_expire)
    );

    // Sequencer state. Counters are cleared by the state transitions, so
    // they never need to wrap past depth_p-1.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state  <= COLLECT;
            r_wr_cnt <= '0;
            r_rd_idx <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        if (r_wr_cnt == LAST_IDX) begin
                            r_state  <= DISPLAY;
                            r_wr_cnt <= '0;
                            r_rd_idx <= '0;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + IW'(1);
                        end
                    end
                end
                DISPLAY: begin
                    if (w_advance) begin
                        if (r_rd_idx == LAST_IDX) begin
                            r_state  <= COLLECT;
                            r_rd_idx <= '0;
                            r_done   <= 1'b1;
                        end else begin
                            r_rd_idx <= r_rd_idx + IW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Matrix buffer: contents survive reset; a fresh matrix overwrites them.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_buf[r_wr_cnt] <= data_i;
        end
    end

    assign ready_o  = !w_in_display;
    assign active_o = w_in_display;
    assign data_o   = w_in_display ? r_buf[r_rd_idx] : '0;
    assign index_o  = w_in_display ? r_rd_idx : '0;
    assign done_o   = r_done;

endmodule
